// File: rtl/des_pkg.sv
// Shared DES constants: permutation index tables, key-schedule shift tables,
// controller state encoding and the permutation helpers built on them.
package des_pkg;

  localparam int BLK_W  = 64;
  localparam int HALF_W = 32;
  localparam int RKEY_W = 48;
  localparam int CD_W   = 28;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_e;

  // Tables use DES 1-based bit numbers; DES bit 1 is the vector MSB.
  localparam int IP_TAB [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int FP_TAB [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

  localparam int PC1_TAB [56] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
    10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};

  localparam int PC2_TAB [48] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10,
    23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};

  // Encrypt rotates left; decrypt starts unrotated and rotates right.
  localparam logic [1:0] SHIFT_ENC [16] = '{
    2'd1,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1};
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1};

  function automatic logic [BLK_W-1:0] ip_f(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[6'(63-k)] = x[6'(64-IP_TAB[6'(k)])];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] fp_f(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[6'(63-k)] = x[6'(64-FP_TAB[6'(k)])];
    return r;
  endfunction

  function automatic logic [2*CD_W-1:0] pc1_f(input logic [BLK_W-1:0] key);
    logic [2*CD_W-1:0] r;
    r = '0;
    for (int k = 0; k < 56; k++) r[6'(55-k)] = key[6'(64-PC1_TAB[6'(k)])];
    return r;
  endfunction

  function automatic logic [RKEY_W-1:0] pc2_f(input logic [2*CD_W-1:0] cd);
    logic [RKEY_W-1:0] r;
    r = '0;
    for (int k = 0; k < 48; k++) r[6'(47-k)] = cd[6'(56-PC2_TAB[6'(k)])];
    return r;
  endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Key-schedule slice: C/D half registers, per-round rotation and PC2.
// The round key reflects the rotated value in the same cycle it is applied.
module des_cd_rotator
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              dec_i,
  input  logic [1:0]        shift_i,
  input  logic [CD_W-1:0]   c_i,
  input  logic [CD_W-1:0]   d_i,
  output logic [RKEY_W-1:0] key_o
);

  logic [CD_W-1:0] c_q, d_q, c_d, d_d, c_rot, d_rot;

  function automatic logic [CD_W-1:0] rot_f(input logic [CD_W-1:0] x, input logic dec,
                                            input logic [1:0] sh);
    logic [CD_W-1:0] r;
    case ({dec, sh})
      3'b0_01: r = {x[26:0], x[27]};
      3'b0_10: r = {x[25:0], x[27:26]};
      3'b1_01: r = {x[0], x[27:1]};
      3'b1_10: r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Rotate, derive the round key, and pick the next C/D value.
  always_comb begin
    c_rot = rot_f(c_q, dec_i, shift_i);
    d_rot = rot_f(d_q, dec_i, shift_i);
    key_o = pc2_f({c_rot, d_rot});
    c_d   = c_q;
    d_d   = d_q;
    if (load_i) begin
      c_d = c_i;
      d_d = d_i;
    end else if (step_i) begin
      c_d = c_rot;
      d_d = d_rot;
    end
  end

  // C/D state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES sequencer: one block at a time, 16 rounds through an external
// combinational f(R,K) engine, IP on entry and FP on exit.
module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_text,
  input  logic [BLK_W-1:0]  in_key,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_text,
  output logic [HALF_W-1:0] rnd_r_o,
  output logic [RKEY_W-1:0] rnd_key_o,
  input  logic [HALF_W-1:0] rnd_f_i,
  output logic              busy
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  state_e            state_q, state_d;
  logic [HALF_W-1:0] l_q, l_d, r_q, r_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [BLK_W-1:0]  out_text_q, out_text_d;
  logic              out_valid_q, out_valid_d;
  logic              fire;
  logic [2*CD_W-1:0] key_cd;
  logic [1:0]        shift;

  assign fire   = in_valid && (state_q == IDLE);
  assign key_cd = pc1_f(in_key);
  assign shift  = dir_q ? SHIFT_DEC[cnt_q] : SHIFT_ENC[cnt_q];

  // Key and direction are captured at the accepting edge so later input changes are ignored.
  des_cd_rotator u_cdrot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (fire),
    .step_i  (state_q == ROUND),
    .dec_i   (dir_q),
    .shift_i (shift),
    .c_i     (key_cd[2*CD_W-1:CD_W]),
    .d_i     (key_cd[CD_W-1:0]),
    .key_o   (rnd_key_o)
  );

  // Next state plus datapath next values; the last round folds the L/R swap into FP.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    out_text_d  = out_text_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d    = LOAD;
        {l_d, r_d} = ip_f(in_text);
        dir_d      = in_decrypt;
        cnt_d      = '0;
      end
      LOAD: state_d = ROUND;
      ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ rnd_f_i;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_text_d  = fp_f({l_q ^ rnd_f_i, r_q});
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      out_text_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      out_text_q  <= out_text_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == LOAD) || (state_q == ROUND);
  assign out_valid = out_valid_q;
  assign out_text  = out_text_q;
  assign rnd_r_o   = r_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: supplies the DES round function f(R,K) and checks
// known-answer vectors, latency, stall, async reset and back-to-back flow.
module tb_des_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_text, in_key, out_text;
  logic [31:0] rnd_r_o, rnd_f_i;
  logic [47:0] rnd_key_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  localparam int P_TAB [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // External round engine: E expansion, key mix, S-boxes, P.
  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b, idx;
    e = '0; s = '0; p = '0;
    for (int j = 0; j < 8; j++)
      for (int m = 0; m < 6; m++)
        e[6'(47-(6*j+m))] = r[5'(31-((4*j+m+31)%32))];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[6'(47-6*j) -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[5'(31-4*j) -: 4] = SBOX[3'(j)][8'(255-4*int'(idx)) -: 4];
    end
    for (int i = 0; i < 32; i++) p[5'(31-i)] = s[5'(32-P_TAB[5'(i)])];
    return p;
  endfunction

  assign rnd_f_i = des_f(rnd_r_o, rnd_key_o);

  des_iter_ctrl #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_text(in_text), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .rnd_r_o(rnd_r_o), .rnd_key_o(rnd_key_o), .rnd_f_i(rnd_f_i), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [47:0] enc_k15;

  // Offers one block from a negedge; inputs are scrambled right after the fire edge.
  // Returns at the negedge where out_valid is first seen (or after the cycle bound).
  task automatic run_block(input logic [63:0] txt, input logic [63:0] key, input logic dec,
                           output logic [63:0] res, output int lat,
                           output logic [47:0] k0, output logic [47:0] k15);
    in_text = txt; in_key = key; in_decrypt = dec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_text = ~txt; in_key = ~key; in_decrypt = ~dec;
    lat = 0; k0 = '0; k15 = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2)  k0  = rnd_key_o;
      if (lat == 17) k15 = rnd_key_o;
    end while (!out_valid && lat < 40);
    res = out_text;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_text = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (out_text !== 64'h0) begin n_err++; $display("FAIL reset_out_text: got %h expected 0", out_text); end
    n_vec++; if (rnd_r_o !== 32'h0) begin n_err++; $display("FAIL reset_rnd_r: got %h expected 0", rnd_r_o); end
    n_vec++; if (rnd_key_o !== 48'h0) begin n_err++; $display("FAIL reset_rnd_key: got %h expected 0", rnd_key_o); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
  endtask

  task automatic test_encrypt();
    logic [63:0] res; int lat; logic [47:0] k0, k15;
    out_ready = 1'b1;
    run_block(PT1, KEY1, 1'b0, res, lat, k0, k15);
    enc_k15 = k15;
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL enc_latency: got %0d expected 18", lat); end
    n_vec++; if (res !== CT1) begin n_err++; $display("FAIL enc_result: got %h expected %h", res, CT1); end
    n_vec++; if (k0 !== K1) begin n_err++; $display("FAIL enc_key_r0: got %h expected %h", k0, K1); end
    n_vec++; if (k15 !== K16) begin n_err++; $display("FAIL enc_key_r15: got %h expected %h", k15, K16); end
    n_vec++; if (dut.u_cdrot.c_q !== 28'hF0CCAAF) begin n_err++; $display("FAIL enc_c_done: got %h expected F0CCAAF", dut.u_cdrot.c_q); end
    n_vec++; if (dut.u_cdrot.d_q !== 28'h556678F) begin n_err++; $display("FAIL enc_d_done: got %h expected 556678F", dut.u_cdrot.d_q); end
    @(negedge clk);
    n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL enc_release: got rdy/vld %b expected 10", {in_ready, out_valid}); end
  endtask

  task automatic test_decrypt();
    logic [63:0] res; int lat; logic [47:0] k0, k15;
    run_block(CT1, KEY1, 1'b1, res, lat, k0, k15);
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL dec_latency: got %0d expected 18", lat); end
    n_vec++; if (res !== PT1) begin n_err++; $display("FAIL dec_result: got %h expected %h", res, PT1); end
    n_vec++; if (k0 !== K16) begin n_err++; $display("FAIL dec_key_r0: got %h expected %h", k0, K16); end
    n_vec++; if (k0 !== enc_k15) begin n_err++; $display("FAIL dec_key_r0_vs_enc_r15: got %h expected %h", k0, enc_k15); end
    n_vec++; if (k15 !== K1) begin n_err++; $display("FAIL dec_key_r15: got %h expected %h", k15, K1); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [63:0] res; int lat; logic [47:0] k0, k15;
    run_block(64'h0, 64'h0, 1'b0, res, lat, k0, k15);
    n_vec++; if (res !== CT0) begin n_err++; $display("FAIL zero_result: got %h expected %h", res, CT0); end
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL zero_latency: got %0d expected 18", lat); end
    n_vec++; if ({dut.u_cdrot.c_q, dut.u_cdrot.d_q} !== 56'h0) begin n_err++; $display("FAIL zero_cd_done: got %h expected 0", {dut.u_cdrot.c_q, dut.u_cdrot.d_q}); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [63:0] res; int lat; logic [47:0] k0, k15; int xfers;
    out_ready = 1'b0;
    run_block(PT1, KEY1, 1'b0, res, lat, k0, k15);
    n_vec++; if (res !== CT1) begin n_err++; $display("FAIL stall_result: got %h expected %h", res, CT1); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; in_valid = ~in_valid;
      @(negedge clk);
      n_vec++; if (out_text !== CT1) begin n_err++; $display("FAIL stall_text[%0d]: got %h expected %h", i, out_text, CT1); end
      n_vec++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL stall_hs[%0d]: got vld/rdy %b expected 10", i, {out_valid, in_ready}); end
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
    end
    n_vec++; if (xfers !== 1) begin n_err++; $display("FAIL stall_xfers: got %0d expected 1", xfers); end
    n_vec++; if ({in_ready, busy} !== 2'b10) begin n_err++; $display("FAIL stall_idle: got rdy/busy %b expected 10", {in_ready, busy}); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat; logic [47:0] k0, k15; int spurious;
    in_text = PT1; in_key = KEY1; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    n_vec++; if (dut.cnt_q !== 4'd7 || busy !== 1'b1) begin n_err++; $display("FAIL mid_cnt: got cnt %0d busy %b expected 7 1", dut.cnt_q, busy); end
    rst_n = 1'b0; #1;
    n_vec++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_err++; $display("FAIL mid_async: got vld/rdy/busy %b expected 010", {out_valid, in_ready, busy}); end
    n_vec++; if (rnd_r_o !== 32'h0 || out_text !== 64'h0) begin n_err++; $display("FAIL mid_clear: got r %h text %h expected 0", rnd_r_o, out_text); end
    @(negedge clk); rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL mid_no_emit: got %0d valid cycles expected 0", spurious); end
    run_block(PT1, KEY1, 1'b0, res, lat, k0, k15);
    n_vec++; if (res !== CT1) begin n_err++; $display("FAIL mid_rerun: got %h expected %h", res, CT1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vt [3] = '{PT1, 64'h0, CT1};
    logic [63:0] vk [3] = '{KEY1, 64'h0, KEY1};
    logic        vd [3] = '{1'b0, 1'b0, 1'b1};
    logic [63:0] ve [3] = '{CT1, CT0, PT1};
    int fire_t [3];
    int fires, outs;
    logic fire;
    fires = 0; outs = 0;
    out_ready = 1'b1;
    in_text = vt[0]; in_key = vk[0]; in_decrypt = vd[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 120 && outs < 3; cyc++) begin
      fire = in_valid && in_ready;
      if (out_valid) begin
        n_vec++; if (out_text !== ve[outs]) begin n_err++; $display("FAIL b2b_result[%0d]: got %h expected %h", outs, out_text, ve[outs]); end
        outs++;
      end
      if (fire && fires < 3) begin fire_t[fires] = cyc; fires++; end
      @(posedge clk); #1;
      if (fire) begin
        if (fires < 3) begin in_text = vt[fires]; in_key = vk[fires]; in_decrypt = vd[fires]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++; if (fires !== 3 || outs !== 3) begin n_err++; $display("FAIL b2b_count: got fires %0d outs %0d expected 3 3", fires, outs); end
    if (fires == 3) begin
      n_vec++; if (fire_t[1] - fire_t[0] !== 19) begin n_err++; $display("FAIL b2b_gap01: got %0d expected 19", fire_t[1] - fire_t[0]); end
      n_vec++; if (fire_t[2] - fire_t[1] !== 19) begin n_err++; $display("FAIL b2b_gap12: got %0d expected 19", fire_t[2] - fire_t[1]); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
